// File: rtl/cache_controller_if.sv
// Request bus from the MEM stage plus the SRAM controller request port of the read cache.
interface cache_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] adr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        ready;
  logic        sram_wr_en;
  logic        sram_rd_en;
  logic [31:0] sram_adr;
  logic [31:0] sram_wr_data;
  logic [63:0] sram_rd_data;
  logic        sram_ready;

  // Cache controller view.
  modport slave (
    input  wr_en, rd_en, adr, wr_data, sram_rd_data, sram_ready,
    output rd_data, ready, sram_wr_en, sram_rd_en, sram_adr, sram_wr_data
  );

  // Environment view: MEM stage plus SRAM controller.
  modport master (
    output wr_en, rd_en, adr, wr_data, sram_rd_data, sram_ready,
    input  rd_data, ready, sram_wr_en, sram_rd_en, sram_adr, sram_wr_data
  );
endinterface

// File: rtl/cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate read cache between the MEM stage
// and the SRAM controller. Read hits complete in the request cycle; misses and writes stall.
module cache_controller #(
  parameter int unsigned INDEX_W = 6,
  parameter int unsigned TAG_W   = 10
) (
  input logic              clk,
  input logic              rst,
  cache_controller_if.slave bus
);

  localparam int unsigned NumSets = 1 << INDEX_W;

  typedef enum logic [1:0] {StIdle, StRdMiss, StWrite} state_e;

  state_e               state_q;
  logic [NumSets-1:0]   valid0_q;
  logic [NumSets-1:0]   valid1_q;
  logic [NumSets-1:0]   lru_q;     // 0: way0 is least recently used
  logic [TAG_W-1:0]     tag_q  [2][NumSets];
  logic [63:0]          data_q [2][NumSets];

  logic [INDEX_W-1:0]   idx;
  logic [TAG_W-1:0]     tag;
  logic                 hit0, hit1, hit;
  logic [63:0]          hit_line;
  logic                 victim;
  logic                 fill;

  assign idx      = bus.adr[INDEX_W+2:3];
  assign tag      = bus.adr[TAG_W+INDEX_W+2:INDEX_W+3];
  assign hit0     = valid0_q[idx] && (tag_q[0][idx] == tag);
  assign hit1     = valid1_q[idx] && (tag_q[1][idx] == tag);
  assign hit      = hit0 || hit1;
  assign hit_line = hit1 ? data_q[1][idx] : data_q[0][idx];
  // First invalid way wins (way0 first), otherwise the LRU way.
  assign victim   = !valid0_q[idx] ? 1'b0 : (!valid1_q[idx] ? 1'b1 : lru_q[idx]);
  // A dropped read request finishes the SRAM access but does not allocate.
  assign fill     = !rst && (state_q == StRdMiss) && bus.sram_ready && bus.rd_en;

  // Combinational handshake back to the pipeline: hit data and miss-fill bypass.
  always_comb begin
    bus.ready   = 1'b1;
    bus.rd_data = '0;
    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          if (bus.wr_en) begin
            bus.ready = 1'b0;
          end else if (bus.rd_en) begin
            if (hit) bus.rd_data = bus.adr[2] ? hit_line[63:32] : hit_line[31:0];
            else     bus.ready   = 1'b0;
          end
        end
        StRdMiss: begin
          bus.ready = bus.sram_ready;
          if (bus.sram_ready) begin
            bus.rd_data = bus.adr[2] ? bus.sram_rd_data[63:32] : bus.sram_rd_data[31:0];
          end
        end
        StWrite: bus.ready = bus.sram_ready;
        default: bus.ready = 1'b1;
      endcase
    end
  end

  // Control FSM: state, valid/LRU bookkeeping and registered SRAM request outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= StIdle;
      valid0_q         <= '0;
      valid1_q         <= '0;
      lru_q            <= '0;
      bus.sram_wr_en   <= 1'b0;
      bus.sram_rd_en   <= 1'b0;
      bus.sram_adr     <= '0;
      bus.sram_wr_data <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.wr_en) begin
            // Write-through: drop any cached copy rather than update it.
            if (hit0) valid0_q[idx] <= 1'b0;
            if (hit1) valid1_q[idx] <= 1'b0;
            bus.sram_wr_en   <= 1'b1;
            bus.sram_adr     <= bus.adr;
            bus.sram_wr_data <= bus.wr_data;
            state_q          <= StWrite;
          end else if (bus.rd_en) begin
            if (hit) begin
              lru_q[idx] <= hit0;
            end else begin
              bus.sram_rd_en <= 1'b1;
              bus.sram_adr   <= {bus.adr[31:3], 3'b000};
              state_q        <= StRdMiss;
            end
          end
        end
        StRdMiss: begin
          if (bus.sram_ready) begin
            bus.sram_rd_en <= 1'b0;
            state_q        <= StIdle;
            if (fill) begin
              if (victim) valid1_q[idx] <= 1'b1;
              else        valid0_q[idx] <= 1'b1;
              lru_q[idx] <= ~victim;
            end
          end
        end
        StWrite: begin
          if (bus.sram_ready) begin
            bus.sram_wr_en <= 1'b0;
            state_q        <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Tag and data arrays; contents are meaningless until the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[victim][idx]  <= tag;
      data_q[victim][idx] <= bus.sram_rd_data;
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: directed scenarios plus random traffic, checked
// against a recency-list cache model and a flat memory model.
module tb_cache_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_controller_if bus();

  cache_controller #(
    .INDEX_W(6),
    .TAG_W  (10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit          is_read;
    bit          hit;
    logic [31:0] data;
  } exp_t;

  int          checks   = 0;
  int          failures = 0;
  exp_t        exp_q[$];
  int unsigned set_q[64][$];           // per set: cached tags, front = least recently used
  logic [31:0] ref_mem[bit [31:0]];    // model's view of memory
  logic [31:0] sram_mem[bit [31:0]];   // SRAM controller's memory
  bit          hold_sram = 1'b0;
  bit          mon_en    = 1'b1;
  int unsigned lat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    bit [31:0] k = {a[31:2], 2'b00};
    return ref_mem.exists(k) ? ref_mem[k] : init_word(k);
  endfunction

  function automatic logic [31:0] sram_word(input logic [31:0] a);
    bit [31:0] k = {a[31:2], 2'b00};
    return sram_mem.exists(k) ? sram_mem[k] : init_word(k);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) set_q[i].delete();
  endtask

  // Issue one request at posedge+1, wait for ready, then release and check idle outputs.
  task automatic do_req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
    exp_t        e;
    int unsigned idx = 32'(a[8:3]);
    int unsigned tag = 32'(a[18:9]);
    int          pos = -1;
    bit          done = 1'b0;
    for (int i = 0; i < set_q[idx].size(); i++) if (set_q[idx][i] == tag) pos = i;
    if (wr) begin
      e.is_read = 1'b0;
      e.hit     = 1'b0;
      e.data    = '0;
      if (pos >= 0) set_q[idx].delete(pos);
      ref_mem[{a[31:2], 2'b00}] = wd;
    end else begin
      e.is_read = 1'b1;
      e.hit     = (pos >= 0);
      e.data    = ref_word(a);
      if (pos >= 0) set_q[idx].delete(pos);
      else if (set_q[idx].size() == 2) void'(set_q[idx].pop_front());
      set_q[idx].push_back(tag);
    end
    exp_q.push_back(e);
    bus.rd_en   = rd;
    bus.wr_en   = wr;
    bus.adr     = a;
    bus.wr_data = wd;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      done = bus.ready;
    end
    check("req_completes", 64'(done), 64'd1);
    @(posedge clk);
    #1;
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    @(negedge clk);
    check("idle_ready", 64'(bus.ready), 64'd1);
    check("idle_rd_data", 64'(bus.rd_data), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: tracks SRAM activity per request and pops the scoreboard on ready.
  int cyc;
  bit saw_rd, saw_wr, bad_bus;
  always @(negedge clk) begin
    exp_t e;
    if (rst || !mon_en) begin
      cyc = 0; saw_rd = 0; saw_wr = 0; bad_bus = 0;
    end else if (bus.rd_en || bus.wr_en) begin
      cyc++;
      if (bus.sram_rd_en) begin
        saw_rd = 1'b1;
        if (bus.sram_adr !== {bus.adr[31:3], 3'b000}) bad_bus = 1'b1;
      end
      if (bus.sram_wr_en) begin
        saw_wr = 1'b1;
        if (bus.sram_adr !== bus.adr || bus.sram_wr_data !== bus.wr_data) bad_bus = 1'b1;
      end
      if (bus.ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_completion", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          if (e.is_read) check("rd_data", 64'(bus.rd_data), 64'(e.data));
          check("single_cycle_hit", 64'(cyc == 1), 64'(e.hit));
          check("sram_rd_used", 64'(saw_rd), 64'(e.is_read && !e.hit));
          check("sram_wr_used", 64'(saw_wr), 64'(!e.is_read));
          check("sram_bus_fields", 64'(bad_bus), 64'd0);
        end
        cyc = 0; saw_rd = 0; saw_wr = 0; bad_bus = 0;
      end
    end
  end

  // SRAM controller model: random latency, one-cycle sram_ready pulse.
  initial begin
    bus.sram_ready   = 1'b0;
    bus.sram_rd_data = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.sram_ready = 1'b0;
      if (rst || hold_sram || !(bus.sram_rd_en || bus.sram_wr_en)) continue;
      lat = $urandom_range(0, 3);
      repeat (lat) begin
        @(posedge clk);
        #1;
      end
      if (rst || hold_sram || !(bus.sram_rd_en || bus.sram_wr_en)) continue;
      if (bus.sram_wr_en) begin
        sram_mem[{bus.sram_adr[31:2], 2'b00}] = bus.sram_wr_data;
      end else begin
        bus.sram_rd_data = {sram_word({bus.sram_adr[31:3], 3'b100}),
                            sram_word({bus.sram_adr[31:3], 3'b000})};
      end
      bus.sram_ready = 1'b1;
    end
  end

  initial begin
    logic [31:0] a;
    int unsigned op;
    bus.rd_en   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.adr     = '0;
    bus.wr_data = '0;
    model_clear();
    ref_mem[32'h400]  = 32'h1111_1111;
    ref_mem[32'h404]  = 32'h2222_2222;
    sram_mem[32'h400] = 32'h1111_1111;
    sram_mem[32'h404] = 32'h2222_2222;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(bus.ready), 64'd1);
    check("rst_rd_data", 64'(bus.rd_data), 64'd0);
    check("rst_sram_rd_en", 64'(bus.sram_rd_en), 64'd0);
    check("rst_sram_wr_en", 64'(bus.sram_wr_en), 64'd0);
    check("rst_sram_adr", 64'(bus.sram_adr), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Miss then hit on the other word of the same line.
    do_req(1'b1, 1'b0, 32'h0000_0400, '0);
    do_req(1'b1, 1'b0, 32'h0000_0404, '0);
    // Two-way fill and LRU replacement at index 0.
    do_req(1'b1, 1'b0, 32'h0000_1400, '0);
    do_req(1'b1, 1'b0, 32'h0000_0400, '0);
    do_req(1'b1, 1'b0, 32'h0000_2400, '0);
    do_req(1'b1, 1'b0, 32'h0000_0400, '0);
    do_req(1'b1, 1'b0, 32'h0000_1400, '0);
    // Write hit invalidates; following read refetches the written data.
    do_req(1'b1, 1'b0, 32'h0000_0400, '0);
    do_req(1'b0, 1'b1, 32'h0000_0400, 32'hDEAD_BEEF);
    do_req(1'b1, 1'b0, 32'h0000_0400, '0);
    // Write miss does not allocate.
    do_req(1'b0, 1'b1, 32'h0000_0800, 32'hCAFE_F00D);
    do_req(1'b1, 1'b0, 32'h0000_0800, '0);
    // Simultaneous read and write is a write.
    do_req(1'b1, 1'b1, 32'h0000_0808, 32'h1234_5678);
    do_req(1'b1, 1'b0, 32'h0000_0808, '0);

    // Reset in the middle of a read miss.
    hold_sram   = 1'b1;
    mon_en      = 1'b0;
    bus.rd_en   = 1'b1;
    bus.adr     = 32'h0000_0C00;
    @(negedge clk);
    @(negedge clk);
    check("miss_sram_rd_en", 64'(bus.sram_rd_en), 64'd1);
    rst = 1'b1;
    #1;
    check("abort_sram_rd_en", 64'(bus.sram_rd_en), 64'd0);
    check("abort_ready", 64'(bus.ready), 64'd1);
    bus.rd_en = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    hold_sram = 1'b0;
    mon_en    = 1'b1;
    @(posedge clk);
    #1;
    do_req(1'b1, 1'b0, 32'h0000_0C00, '0);
    do_req(1'b1, 1'b0, 32'h0000_0404, '0);

    // Random traffic over a few sets and tags to exercise hits, evictions and invalidations.
    for (int i = 0; i < 300; i++) begin
      a  = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 3) |
           (32'($urandom_range(0, 1)) << 2);
      op = $urandom_range(0, 9);
      if (op < 2)       do_req(1'b0, 1'b1, a, $urandom);
      else if (op == 9) do_req(1'b1, 1'b1, a, $urandom);
      else              do_req(1'b1, 1'b0, a, '0);
    end

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
